bp_be_ptw_miss_arb: RTL and testbench

Sits directly upstream of the page-table walker. It captures ITLB and DTLB misses into one pending slot each, arbitrates between them, and presents exactly one miss per walk to the walker. It tracks the outstanding owner and routes the walker's fill/fault result back to the requesting side as a one-cycle pulse. D-side flush cancels or squashes data misses.

---
 rtl/bp_be_ptw_miss_arb.sv | 203 ++++++++++++++++++++
 tb/tb_bp_be_ptw_miss_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_ptw_miss_arb.sv
// Miss arbiter in front of the page-table walker. Holds one pending I and one pending D miss,
// issues one walk at a time round-robin, and routes the fill/fault result back to the owner.
module bp_be_ptw_miss_arb #(
   parameter int unsigned vaddr_width_p = 39,
   parameter int unsigned ptag_width_p  = 28
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     itlb_miss_v_i,
   output logic                     itlb_miss_ready_o,
   input  logic [vaddr_width_p-1:0] itlb_miss_vaddr_i,

   input  logic                     dtlb_miss_v_i,
   output logic                     dtlb_miss_ready_o,
   input  logic [vaddr_width_p-1:0] dtlb_miss_vaddr_i,
   input  logic                     dtlb_miss_store_i,
   input  logic                     dtlb_flush_i,

   input  logic [1:0]               priv_mode_i,
   input  logic                     mstatus_sum_i,
   input  logic                     mstatus_mxr_i,
   input  logic [ptag_width_p-1:0]  satp_ppn_i,

   input  logic                     ptw_busy_i,
   output logic                     ptw_instr_miss_v_o,
   output logic                     ptw_load_miss_v_o,
   output logic                     ptw_store_miss_v_o,
   output logic [vaddr_width_p-1:0] ptw_vaddr_o,
   output logic [1:0]               ptw_priv_mode_o,
   output logic                     ptw_mstatus_sum_o,
   output logic                     ptw_mstatus_mxr_o,
   output logic [ptag_width_p-1:0]  ptw_base_ppn_o,

   input  logic                     ptw_fill_v_i,
   input  logic                     ptw_fill_page_fault_i,

   output logic                     itlb_fill_v_o,
   output logic                     itlb_fault_o,
   output logic                     dtlb_fill_v_o,
   output logic                     dtlb_fault_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e                     state_q, state_d;
   logic                       grant_q, grant_d;   // 0: I owns the walk, 1: D owns it
   logic                       prio_q, prio_d;
   logic                       squash_q, squash_d;

   logic                       i_v_q, i_v_d;
   logic [vaddr_width_p-1:0]   i_vaddr_q, i_vaddr_d;
   logic [1:0]                 i_priv_q, i_priv_d;
   logic                       i_sum_q, i_sum_d;
   logic                       i_mxr_q, i_mxr_d;

   logic                       d_v_q, d_v_d;
   logic [vaddr_width_p-1:0]   d_vaddr_q, d_vaddr_d;
   logic                       d_store_q, d_store_d;
   logic [1:0]                 d_priv_q, d_priv_d;
   logic                       d_sum_q, d_sum_d;
   logic                       d_mxr_q, d_mxr_d;

   logic                       ifill_q, ifill_d, ifault_q, ifault_d;
   logic                       dfill_q, dfill_d, dfault_q, dfault_d;

   logic fill_now, i_acc, d_acc, d_out, i_elig, d_elig, can_grant, sel_d, d_quiet;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      prio_d    = prio_q;
      squash_d  = squash_q;
      i_v_d     = i_v_q;
      i_vaddr_d = i_vaddr_q;
      i_priv_d  = i_priv_q;
      i_sum_d   = i_sum_q;
      i_mxr_d   = i_mxr_q;
      d_v_d     = d_v_q;
      d_vaddr_d = d_vaddr_q;
      d_store_d = d_store_q;
      d_priv_d  = d_priv_q;
      d_sum_d   = d_sum_q;
      d_mxr_d   = d_mxr_q;

      fill_now = (state_q == StWait) && ptw_fill_v_i;
      i_acc    = itlb_miss_v_i & ~i_v_q;
      d_acc    = dtlb_miss_v_i & ~d_v_q & ~dtlb_flush_i;
      d_out    = (state_q != StIdle) & grant_q;
      // The slot being retired by this fill is not a grant candidate.
      i_elig    = i_v_q & ~(fill_now & ~grant_q);
      d_elig    = d_v_q & ~dtlb_flush_i & ~(fill_now & grant_q);
      can_grant = ((state_q == StIdle) || fill_now) && (i_elig || d_elig) && !ptw_busy_i;
      sel_d     = (i_elig & d_elig) ? prio_q : d_elig;
      d_quiet   = squash_q | dtlb_flush_i;

      if (i_acc) begin
         i_v_d     = 1'b1;
         i_vaddr_d = itlb_miss_vaddr_i;
         i_priv_d  = priv_mode_i;
         i_sum_d   = mstatus_sum_i;
         i_mxr_d   = mstatus_mxr_i;
      end
      if (fill_now && !grant_q) i_v_d = 1'b0;

      if (d_acc) begin
         d_v_d     = 1'b1;
         d_vaddr_d = dtlb_miss_vaddr_i;
         d_store_d = dtlb_miss_store_i;
         d_priv_d  = priv_mode_i;
         d_sum_d   = mstatus_sum_i;
         d_mxr_d   = mstatus_mxr_i;
      end
      if (dtlb_flush_i && !d_out) d_v_d = 1'b0;
      if (fill_now && grant_q)    d_v_d = 1'b0;

      if (fill_now)                  squash_d = 1'b0;
      else if (dtlb_flush_i && d_out) squash_d = 1'b1;

      ifill_d  = fill_now & ~grant_q & ~ptw_fill_page_fault_i;
      ifault_d = fill_now & ~grant_q &  ptw_fill_page_fault_i;
      dfill_d  = fill_now &  grant_q & ~d_quiet & ~ptw_fill_page_fault_i;
      dfault_d = fill_now &  grant_q & ~d_quiet &  ptw_fill_page_fault_i;

      unique case (state_q)
         StIdle:  if (can_grant) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (fill_now) state_d = can_grant ? StIssue : StIdle;
         default: state_d = StIdle;
      endcase

      if (can_grant) begin
         grant_d = sel_d;
         if (i_elig && d_elig) prio_d = ~sel_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         grant_q  <= 1'b0;
         prio_q   <= 1'b0;
         squash_q <= 1'b0;
         i_v_q    <= 1'b0;
         d_v_q    <= 1'b0;
         ifill_q  <= 1'b0;
         ifault_q <= 1'b0;
         dfill_q  <= 1'b0;
         dfault_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         prio_q   <= prio_d;
         squash_q <= squash_d;
         i_v_q    <= i_v_d;
         d_v_q    <= d_v_d;
         ifill_q  <= ifill_d;
         ifault_q <= ifault_d;
         dfill_q  <= dfill_d;
         dfault_q <= dfault_d;
      end
   end

   always_ff @(posedge clk_i) begin
      i_vaddr_q <= i_vaddr_d;
      i_priv_q  <= i_priv_d;
      i_sum_q   <= i_sum_d;
      i_mxr_q   <= i_mxr_d;
      d_vaddr_q <= d_vaddr_d;
      d_store_q <= d_store_d;
      d_priv_q  <= d_priv_d;
      d_sum_q   <= d_sum_d;
      d_mxr_q   <= d_mxr_d;
   end

   assign itlb_miss_ready_o  = ~i_v_q;
   assign dtlb_miss_ready_o  = ~d_v_q;

   assign ptw_instr_miss_v_o = (state_q == StIssue) & ~grant_q;
   assign ptw_load_miss_v_o  = (state_q == StIssue) &  grant_q & ~d_store_q;
   assign ptw_store_miss_v_o = (state_q == StIssue) &  grant_q &  d_store_q;
   assign ptw_vaddr_o        = grant_q ? d_vaddr_q : i_vaddr_q;
   assign ptw_priv_mode_o    = grant_q ? d_priv_q  : i_priv_q;
   assign ptw_mstatus_sum_o  = grant_q ? d_sum_q   : i_sum_q;
   assign ptw_mstatus_mxr_o  = grant_q ? d_mxr_q   : i_mxr_q;
   assign ptw_base_ppn_o     = satp_ppn_i;

   assign itlb_fill_v_o = ifill_q;
   assign itlb_fault_o  = ifault_q;
   assign dtlb_fill_v_o = dfill_q;
   assign dtlb_fault_o  = dfault_q;

   // A walk abandoned by reset may still deliver its fill while idle; that one is tolerated.
   logic walk_lost_q;
   always_ff @(posedge clk_i) begin
      if (reset_i)           walk_lost_q <= walk_lost_q | (state_q != StIdle);
      else if (ptw_fill_v_i) walk_lost_q <= 1'b0;
   end

   fill_only_in_wait: assert property (@(posedge clk_i) disable iff (reset_i)
      ptw_fill_v_i |-> (state_q == StWait) || ((state_q == StIdle) && walk_lost_q));

endmodule

// File: tb/tb_bp_be_ptw_miss_arb.sv
// Scoreboard bench for bp_be_ptw_miss_arb: stimulus queues expected walker issues and fill
// pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_bp_be_ptw_miss_arb;
   localparam int unsigned VW = 39;
   localparam int unsigned PW = 28;
   typedef logic [74:0] ev_t;

   localparam logic [3:0] KInstr = 4'd1, KLoad = 4'd2, KStore = 4'd3;
   localparam logic [3:0] KIFill = 4'd4, KIFault = 4'd5, KDFill = 4'd6, KDFault = 4'd7;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          itlb_miss_v_i = 0, dtlb_miss_v_i = 0, dtlb_miss_store_i = 0, dtlb_flush_i = 0;
   logic [VW-1:0] itlb_miss_vaddr_i = '0, dtlb_miss_vaddr_i = '0;
   logic [1:0]    priv_mode_i = 0;
   logic          mstatus_sum_i = 0, mstatus_mxr_i = 0, ptw_busy_i = 0;
   logic [PW-1:0] satp_ppn_i = '0;
   logic          ptw_fill_v_i = 0, ptw_fill_page_fault_i = 0;
   logic          itlb_miss_ready_o, dtlb_miss_ready_o;
   logic          ptw_instr_miss_v_o, ptw_load_miss_v_o, ptw_store_miss_v_o;
   logic [VW-1:0] ptw_vaddr_o;
   logic [1:0]    ptw_priv_mode_o;
   logic          ptw_mstatus_sum_o, ptw_mstatus_mxr_o;
   logic [PW-1:0] ptw_base_ppn_o;
   logic          itlb_fill_v_o, itlb_fault_o, dtlb_fill_v_o, dtlb_fault_o;

   bp_be_ptw_miss_arb #(.vaddr_width_p(VW), .ptag_width_p(PW)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .itlb_miss_v_i(itlb_miss_v_i), .itlb_miss_ready_o(itlb_miss_ready_o),
      .itlb_miss_vaddr_i(itlb_miss_vaddr_i),
      .dtlb_miss_v_i(dtlb_miss_v_i), .dtlb_miss_ready_o(dtlb_miss_ready_o),
      .dtlb_miss_vaddr_i(dtlb_miss_vaddr_i), .dtlb_miss_store_i(dtlb_miss_store_i),
      .dtlb_flush_i(dtlb_flush_i), .priv_mode_i(priv_mode_i),
      .mstatus_sum_i(mstatus_sum_i), .mstatus_mxr_i(mstatus_mxr_i), .satp_ppn_i(satp_ppn_i),
      .ptw_busy_i(ptw_busy_i), .ptw_instr_miss_v_o(ptw_instr_miss_v_o),
      .ptw_load_miss_v_o(ptw_load_miss_v_o), .ptw_store_miss_v_o(ptw_store_miss_v_o),
      .ptw_vaddr_o(ptw_vaddr_o), .ptw_priv_mode_o(ptw_priv_mode_o),
      .ptw_mstatus_sum_o(ptw_mstatus_sum_o), .ptw_mstatus_mxr_o(ptw_mstatus_mxr_o),
      .ptw_base_ppn_o(ptw_base_ppn_o), .ptw_fill_v_i(ptw_fill_v_i),
      .ptw_fill_page_fault_i(ptw_fill_page_fault_i),
      .itlb_fill_v_o(itlb_fill_v_o), .itlb_fault_o(itlb_fault_o),
      .dtlb_fill_v_o(dtlb_fill_v_o), .dtlb_fault_o(dtlb_fault_o)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_fail   = 0;
   ev_t sb_q[$];

   task automatic check(input string name, input ev_t act, input ev_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ev_t mk_ev(input logic [3:0] k, input logic [VW-1:0] va,
                                 input logic [1:0] pr, input logic s, input logic m,
                                 input logic [PW-1:0] ppn);
      return {k, va, pr, s, m, ppn};
   endfunction

   task automatic sb_pop(input ev_t act);
      if (sb_q.size() == 0) check("sb_unexpected_output", act, '0);
      else                  check("sb_event", act, sb_q.pop_front());
   endtask

   task automatic pop_issue(input logic [3:0] k);
      sb_pop(mk_ev(k, ptw_vaddr_o, ptw_priv_mode_o, ptw_mstatus_sum_o, ptw_mstatus_mxr_o,
                   ptw_base_ppn_o));
   endtask

   // Monitor: fill/fault pulses are ordered ahead of an issue in the same cycle.
   always @(negedge clk) begin
      if (itlb_fill_v_o)      sb_pop(mk_ev(KIFill,  '0, 2'b0, 1'b0, 1'b0, '0));
      if (itlb_fault_o)       sb_pop(mk_ev(KIFault, '0, 2'b0, 1'b0, 1'b0, '0));
      if (dtlb_fill_v_o)      sb_pop(mk_ev(KDFill,  '0, 2'b0, 1'b0, 1'b0, '0));
      if (dtlb_fault_o)       sb_pop(mk_ev(KDFault, '0, 2'b0, 1'b0, 1'b0, '0));
      if (ptw_instr_miss_v_o) pop_issue(KInstr);
      if (ptw_load_miss_v_o)  pop_issue(KLoad);
      if (ptw_store_miss_v_o) pop_issue(KStore);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_i(input logic [VW-1:0] va);
      check("i_ready_before_req", ev_t'(itlb_miss_ready_o), ev_t'(1));
      itlb_miss_v_i     = 1'b1;
      itlb_miss_vaddr_i = va;
   endtask

   task automatic drive_d(input logic [VW-1:0] va, input logic st);
      check("d_ready_before_req", ev_t'(dtlb_miss_ready_o), ev_t'(1));
      dtlb_miss_v_i     = 1'b1;
      dtlb_miss_vaddr_i = va;
      dtlb_miss_store_i = st;
   endtask

   // Accept edge; afterwards scramble the sampled-at-accept inputs.
   task automatic accept(input logic [1:0] pr, input logic s, input logic m);
      priv_mode_i   = pr;
      mstatus_sum_i = s;
      mstatus_mxr_i = m;
      tick();
      itlb_miss_v_i     = 1'b0;
      dtlb_miss_v_i     = 1'b0;
      itlb_miss_vaddr_i = '1;
      dtlb_miss_vaddr_i = '1;
      dtlb_miss_store_i = ~dtlb_miss_store_i;
      priv_mode_i       = ~pr;
      mstatus_sum_i     = ~s;
      mstatus_mxr_i     = ~m;
   endtask

   task automatic wait_issue();
      int n = 0;
      while (!(ptw_instr_miss_v_o | ptw_load_miss_v_o | ptw_store_miss_v_o) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("issue_timeout", ev_t'(1), ev_t'(0));
   endtask

   task automatic fill(input int dly, input logic fault);
      repeat (dly) tick();
      ptw_fill_v_i          = 1'b1;
      ptw_fill_page_fault_i = fault;
      tick();
      ptw_fill_v_i          = 1'b0;
      ptw_fill_page_fault_i = 1'b0;
   endtask

   localparam ev_t NoEv = '0;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] ppn;
      repeat (3) tick();
      reset_i = 1'b0;
      check("reset_ready", ev_t'({itlb_miss_ready_o, dtlb_miss_ready_o}), ev_t'(2'b11));
      check("reset_outputs", ev_t'({ptw_instr_miss_v_o, ptw_load_miss_v_o, ptw_store_miss_v_o,
            itlb_fill_v_o, itlb_fault_o, dtlb_fill_v_o, dtlb_fault_o}), NoEv);

      // Single I miss, S-mode, fill 5 cycles after issue.
      ppn = 28'h0AB_CDEF; satp_ppn_i = ppn;
      sb_q.push_back(mk_ev(KInstr, 39'h0_4000_1000, 2'b01, 1'b1, 1'b0, ppn));
      sb_q.push_back(mk_ev(KIFill, '0, 2'b0, 1'b0, 1'b0, '0));
      drive_i(39'h0_4000_1000);
      accept(2'b01, 1'b1, 1'b0);
      check("i_ready_while_pending", ev_t'(itlb_miss_ready_o), ev_t'(0));
      wait_issue();
      fill(5, 1'b0);
      tick();
      check("i_ready_after_fill", ev_t'(itlb_miss_ready_o), ev_t'(1));

      // Simultaneous I + D store: I first, D issued back-to-back with the I fill pulse.
      ppn = 28'h123_4567; satp_ppn_i = ppn;
      sb_q.push_back(mk_ev(KInstr, 39'h0_0000_2000, 2'b00, 1'b0, 1'b1, ppn));
      sb_q.push_back(mk_ev(KIFill, '0, 2'b0, 1'b0, 1'b0, '0));
      sb_q.push_back(mk_ev(KStore, 39'h7_F000_0008, 2'b00, 1'b0, 1'b1, ppn));
      sb_q.push_back(mk_ev(KDFill, '0, 2'b0, 1'b0, 1'b0, '0));
      drive_i(39'h0_0000_2000);
      drive_d(39'h7_F000_0008, 1'b1);
      accept(2'b00, 1'b0, 1'b1);
      wait_issue();
      fill(5, 1'b0);
      wait_issue();
      check("store_issue_turnaround", ev_t'(ptw_store_miss_v_o), ev_t'(1));
      fill(3, 1'b0);
      tick();

      // Second simultaneous pair: round-robin gives D (load) first.
      sb_q.push_back(mk_ev(KLoad, 39'h0_1234_5678, 2'b11, 1'b1, 1'b1, ppn));
      sb_q.push_back(mk_ev(KDFill, '0, 2'b0, 1'b0, 1'b0, '0));
      sb_q.push_back(mk_ev(KInstr, 39'h0_0000_3000, 2'b11, 1'b1, 1'b1, ppn));
      sb_q.push_back(mk_ev(KIFill, '0, 2'b0, 1'b0, 1'b0, '0));
      drive_i(39'h0_0000_3000);
      drive_d(39'h0_1234_5678, 1'b0);
      accept(2'b11, 1'b1, 1'b1);
      wait_issue();
      fill(2, 1'b0);
      wait_issue();
      fill(2, 1'b0);
      tick();

      // D load held off by ptw_busy_i for 3 cycles.
      ppn = 28'hFED_CBA9; satp_ppn_i = ppn;
      sb_q.push_back(mk_ev(KLoad, 39'h1_0000_0040, 2'b01, 1'b0, 1'b0, ppn));
      sb_q.push_back(mk_ev(KDFault, '0, 2'b0, 1'b0, 1'b0, '0));
      ptw_busy_i = 1'b1;
      drive_d(39'h1_0000_0040, 1'b0);
      accept(2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("no_issue_while_busy", ev_t'(ptw_load_miss_v_o), ev_t'(0));
         tick();
      end
      ptw_busy_i = 1'b0;
      wait_issue();
      fill(4, 1'b1);
      tick();

      // Flush mid-walk: walk completes but D pulses are suppressed.
      sb_q.push_back(mk_ev(KLoad, 39'h0_0BAD_0000, 2'b00, 1'b1, 1'b0, ppn));
      drive_d(39'h0_0BAD_0000, 1'b0);
      accept(2'b00, 1'b1, 1'b0);
      wait_issue();
      tick();
      tick();
      dtlb_flush_i = 1'b1;
      tick();
      dtlb_flush_i = 1'b0;
      fill(3, 1'b0);
      tick();
      check("d_ready_after_squash", ev_t'(dtlb_miss_ready_o), ev_t'(1));
      sb_q.push_back(mk_ev(KStore, 39'h0_0600_0010, 2'b01, 1'b0, 1'b0, ppn));
      sb_q.push_back(mk_ev(KDFill, '0, 2'b0, 1'b0, 1'b0, '0));
      drive_d(39'h0_0600_0010, 1'b1);
      accept(2'b01, 1'b0, 1'b0);
      wait_issue();
      fill(2, 1'b0);
      tick();

      // Flush of a pending, not yet issued, D miss: slot cleared, never issued.
      ptw_busy_i = 1'b1;
      drive_d(39'h0_0700_0000, 1'b0);
      accept(2'b01, 1'b0, 1'b0);
      dtlb_flush_i = 1'b1;
      tick();
      dtlb_flush_i = 1'b0;
      check("d_ready_after_pending_flush", ev_t'(dtlb_miss_ready_o), ev_t'(1));
      ptw_busy_i = 1'b0;
      repeat (3) tick();

      // Flush on the same cycle as the accept: request dropped.
      drive_d(39'h0_0800_0000, 1'b0);
      dtlb_flush_i = 1'b1;
      accept(2'b01, 1'b0, 1'b0);
      dtlb_flush_i = 1'b0;
      check("d_ready_flush_on_accept", ev_t'(dtlb_miss_ready_o), ev_t'(1));
      repeat (3) tick();

      // I miss with page fault.
      sb_q.push_back(mk_ev(KInstr, 39'h0_4000_2000, 2'b01, 1'b0, 1'b0, ppn));
      sb_q.push_back(mk_ev(KIFault, '0, 2'b0, 1'b0, 1'b0, '0));
      drive_i(39'h0_4000_2000);
      accept(2'b01, 1'b0, 1'b0);
      wait_issue();
      fill(3, 1'b1);
      tick();

      // Reset while waiting, then a stray fill: nothing comes out.
      sb_q.push_back(mk_ev(KInstr, 39'h0_5000_0000, 2'b00, 1'b1, 1'b1, ppn));
      drive_i(39'h0_5000_0000);
      accept(2'b00, 1'b1, 1'b1);
      wait_issue();
      tick();
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      fill(1, 1'b0);
      tick();
      check("ready_after_reset_mid_walk",
            ev_t'({itlb_miss_ready_o, dtlb_miss_ready_o}), ev_t'(2'b11));
      check("outputs_after_stray_fill", ev_t'({ptw_instr_miss_v_o, ptw_load_miss_v_o,
            ptw_store_miss_v_o, itlb_fill_v_o, itlb_fault_o, dtlb_fill_v_o, dtlb_fault_o}), NoEv);

      repeat (5) tick();
      check("sb_drain", ev_t'(sb_q.size()), ev_t'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
